frame_align_40: RTL and testbench
=================================

# frame_align_40

Byte/frame aligner downstream of the 40 MHz serializer/deserializer path. Consumes the recovered serial bit stream one bit per enabled `clock_40` cycle, hunts for a sync byte, confirms frame periodicity, then emits aligned payload bytes with a valid strobe. It gives the deserializer output a known byte boundary, which the fixed-phase deserializers do not provide.

## Interface
- `SYNC_WORD`, 8'hBC: sync byte that marks the start of each frame.
- `PAYLOAD_LEN`, 4: payload bytes per frame, following each sync byte; legal range 1–255.
- `LOCK_COUNT`, 3: consecutive correctly spaced sync bytes required to lock; legal range 1–15.
- `UNLOCK_COUNT`, 4: consecutive missed sync slots that drop lock; legal range 1–15.
- `clock_40`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial bit, MSB of each byte first.
- `enable`  in  1  bit-valid; `data_in` is sampled only when high.
- `data_out`  out  8  aligned payload byte.
- `data_valid`  out  1  one-cycle pulse when `data_out` is new.
- `frame_start`  out  1  high with `data_valid` for the first payload byte of a frame.
- `locked`  out  1  high while in LOCKED.
- `sync_err_count`  out  8  present only with `FRAME_ALIGN_STATS_EN`.

## Operation
- Shift register `sr <= {sr[6:0], data_in}` on every enabled cycle. All comparisons use the post-shift value.
- Bit counter: 3 bits, wraps 7→0. Byte counter: 0..PAYLOAD_LEN, where 0 is the sync slot.
- HUNT:
  - Each enabled bit, compare the post-shift byte with `SYNC_WORD`.
  - On match: bit counter ← 0, byte counter ← 1, match count ← 1, go to VERIFY. If `LOCK_COUNT` = 1, go directly to LOCKED instead.
- VERIFY:
  - Bytes complete on the enabled cycle where the bit counter wraps.
  - Payload bytes are not output.
  - At the sync slot, a match increments the match count. Reaching `LOCK_COUNT` goes to LOCKED.
  - A mismatch goes to HUNT. Hunting resumes on the next enabled bit; the failing cycle is not re-checked.
- LOCKED:
  - Each completed payload byte goes to `data_out` with `data_valid`. Byte 1 of each frame also asserts `frame_start`.
  - Sync slot match: miss count ← 0.
  - Sync slot mismatch: miss count +1. On reaching `UNLOCK_COUNT`, go to HUNT immediately. Below that count, flywheel: keep the frame timing and output that frame's payload.
- While `enable` is low, all state holds and `data_valid`/`frame_start` are 0.
- Reset values:
  - State HUNT.
  - `sr`, all counters, `data_out` = 0.
  - `data_valid`, `frame_start`, `locked` = 0.
  - `sync_err_count` = 0.
- Reset asserted mid-frame: immediate return to the reset values; no partial byte is emitted.

## Timing
- `data_valid` is registered. It is high for exactly the one cycle after the enabled edge that samples bit 0 (the LSB) of a payload byte.
- Latency from that bit to `data_out`: 1 clock.
- `locked` is registered from the state:
  - Rises 1 cycle after the edge that samples the final sync byte's LSB.
  - Falls 1 cycle after the edge that samples the LSB of the sync slot that reached `UNLOCK_COUNT`.
- Back-to-back bytes produce at most one pulse per 8 enabled cycles.
- If the LOCKED→HUNT transition coincides with a byte boundary, no `data_valid` is produced on that boundary.

## Configuration
- `FRAME_ALIGN_STATS_EN` defined:
  - Adds `sync_err_count`, an 8-bit counter that increments on every missed sync slot in LOCKED, including the one that causes unlock.
  - It saturates at 8'hFF and is cleared only by reset.
- `FRAME_ALIGN_STATS_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `frame_align_pkg` holds:
  - State enum {HUNT, VERIFY, LOCKED}.
  - Default constants for `SYNC_WORD`, `PAYLOAD_LEN`, `LOCK_COUNT` and `UNLOCK_COUNT`.
- Single module. The shift register, counters and FSM are tightly coupled, so no sub-module.

## Test plan
All scenarios use default parameters and continuous `enable` unless stated.
- Three frames of BC 11 22 33 44, then a fourth:
  - `locked` rises after the third BC.
  - Fourth frame outputs 11 (with `frame_start`), 22, 33, 44.
  - Exactly 4 `data_valid` pulses in that frame.
- 5 random bits, then frames of BC A5 5A 0F F0:
  - Aligns despite the bit offset.
  - After lock, `data_out` sequence is A5, 5A, 0F, F0.
- Locked stream where one sync byte is replaced by 8'h00:
  - Stays locked; that frame's payload is still output.
  - `sync_err_count` = 1 with `FRAME_ALIGN_STATS_EN`.
- Locked stream followed by 4 consecutive corrupted sync slots:
  - `locked` falls 1 cycle after the 4th bad slot's LSB.
  - No further `data_valid` until relock (3 good syncs).
- `enable` toggled 1-0-1-0 while streaming frames: output values match the continuous case; pulses are spaced by 8 enabled cycles.
- `reset` driven low mid-payload while locked:
  - All outputs go to 0 immediately.
  - After release, relock requires 3 fresh syncs.

Source files
------------

// File: rtl/frame_align_pkg.sv
// rtl/frame_align_pkg.sv - shared types and default constants for frame_align_40
//
// Purpose: aligner FSM state encoding and the default framing constants
//          (sync byte, payload length, lock/unlock thresholds).
// Ports:   none (package).
package frame_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]  DEF_SYNC_WORD    = 8'hBC;
  localparam int unsigned DEF_PAYLOAD_LEN  = 4;
  localparam int unsigned DEF_LOCK_COUNT   = 3;
  localparam int unsigned DEF_UNLOCK_COUNT = 4;

endpackage

// File: rtl/frame_align_40.sv
// rtl/frame_align_40.sv - serial bit stream byte/frame aligner with sync-byte lock
//
// Purpose: takes one recovered serial bit per enabled clock, hunts for the
//          sync byte, confirms LOCK_COUNT correctly spaced syncs, then emits
//          payload bytes on a fixed byte boundary. Missed syncs are
//          flywheeled until UNLOCK_COUNT consecutive misses drop lock.
// Optional feature macro: FRAME_ALIGN_STATS_EN (adds sync_err_count).
// Ports:
//   clock_40       in   sole clock, rising edge
//   reset          in   asynchronous, active-low reset
//   data_in        in   serial bit, MSB of each byte first
//   enable         in   bit-valid; data_in sampled only when high
//   data_out       out  [7:0] aligned payload byte
//   data_valid     out  one-cycle pulse when data_out is new
//   frame_start    out  with data_valid on payload byte 1 of a frame
//   locked         out  high while aligned
//   sync_err_count out  [7:0] saturating missed-sync counter (FRAME_ALIGN_STATS_EN only)
module frame_align_40
  import frame_align_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD    = DEF_SYNC_WORD,
  parameter int unsigned PAYLOAD_LEN  = DEF_PAYLOAD_LEN,
  parameter int unsigned LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int unsigned UNLOCK_COUNT = DEF_UNLOCK_COUNT
) (
  input  logic       clock_40,
  input  logic       reset,
  input  logic       data_in,
  input  logic       enable,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       locked
`ifdef FRAME_ALIGN_STATS_EN
  ,
  output logic [7:0] sync_err_count
`endif
);

  localparam logic [7:0] PLEN     = 8'(PAYLOAD_LEN);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  state_t     state;
  state_t     state_next;

  // Only the seven most recent bits need storing: the eighth is always the
  // incoming data_in, so the post-shift byte is {sr_q, data_in}.
  logic [6:0] sr_q;
  logic [7:0] sr_next;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;   // 0 = sync slot, 1..PAYLOAD_LEN = payload
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;

  logic       sync_hit;
  logic       byte_done;
  logic       sync_slot;
  logic       slot_miss;

  // Next-state and decode.
  always_comb begin
    state_next = state;
    sr_next    = {sr_q, data_in};
    sync_hit   = (sr_next == SYNC_WORD);
    byte_done  = enable && (bit_cnt == 3'd7);
    sync_slot  = (byte_cnt == 8'd0);
    slot_miss  = 1'b0;
    case (state)
      HUNT: begin
        if (enable && sync_hit) begin
          state_next = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (byte_done && sync_slot) begin
          if (!sync_hit) begin
            state_next = HUNT;
          end else if (match_cnt + 4'd1 >= LOCK_N) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (byte_done && sync_slot && !sync_hit) begin
          slot_miss = 1'b1;
          if (miss_cnt + 4'd1 >= UNLOCK_N) begin
            state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // State register; locked mirrors the registered state.
  always_ff @(posedge clock_40 or negedge reset) begin
    if (!reset) begin
      state  <= HUNT;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      locked <= (state_next == LOCKED);
    end
  end

  // Shift register, counters and output byte.
  always_ff @(posedge clock_40 or negedge reset) begin
    if (!reset) begin
      sr_q        <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        sr_q <= sr_next[6:0];
        if (state == HUNT) begin
          // A sync hit makes this bit the sync LSB, so the next bit opens
          // payload byte 1 with a fresh bit count.
          if (sync_hit) begin
            bit_cnt   <= 3'd0;
            byte_cnt  <= 8'd1;
            match_cnt <= 4'd1;
            miss_cnt  <= 4'd0;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            byte_cnt <= (byte_cnt == PLEN) ? 8'd0 : byte_cnt + 8'd1;
            if (sync_slot) begin
              if (sync_hit) begin
                miss_cnt <= 4'd0;
                if (state == VERIFY) begin
                  match_cnt <= match_cnt + 4'd1;
                end
              end else if (slot_miss) begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else if (state == LOCKED) begin
              // Payload only leaves the block while locked, including
              // flywheeled frames whose sync was missed.
              data_out    <= sr_next;
              data_valid  <= 1'b1;
              frame_start <= (byte_cnt == 8'd1);
            end
          end
        end
      end
    end
  end

`ifdef FRAME_ALIGN_STATS_EN
  // Counts every missed sync slot while locked, including the unlocking one.
  always_ff @(posedge clock_40 or negedge reset) begin
    if (!reset) begin
      sync_err_count <= '0;
    end else if (slot_miss && (sync_err_count != 8'hFF)) begin
      sync_err_count <= sync_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_align_40.sv
// tb/tb_frame_align_40.sv - self-checking bench for frame_align_40
module tb_frame_align_40;

  logic       clk;
  logic       rst_n;
  logic       data_in;
  logic       enable;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic       locked;
`ifdef FRAME_ALIGN_STATS_EN
  logic [7:0] sync_err_count;
`endif

  frame_align_40 dut (
    .clock_40   (clk),
    .reset      (rst_n),
    .data_in    (data_in),
    .enable     (enable),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_start(frame_start),
    .locked     (locked)
`ifdef FRAME_ALIGN_STATS_EN
    ,
    .sync_err_count(sync_err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cap_data[$];
  logic       cap_fs[$];
  int         cap_en[$];
  int         en_cnt = 0;

  always @(posedge clk) if (enable) en_cnt = en_cnt + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      cap_data.push_back(data_out);
      cap_fs.push_back(frame_start);
      cap_en.push_back(en_cnt);
    end
  end

  typedef struct {
    logic [39:0] frame;
    int          exp_n;
    logic [31:0] exp_data;
    logic        exp_locked;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_fs.delete();
    cap_en.delete();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
    enable  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // One disabled cycle lets the last byte's pulse be captured before checking.
  task automatic gap();
    @(negedge clk);
    enable  = 1'b0;
    data_in = 1'b0;
    #2;
  endtask

  task automatic send_frame(input logic [39:0] f);
    clear_caps();
    for (int k = 4; k >= 0; k--) send_byte(f[k*8 +: 8]);
    gap();
  endtask

  task automatic check_out(input string name, input int exp_n, input logic [31:0] exp_data);
    logic [31:0] d;
    logic [3:0]  fs;
    chk({name, "_count"}, cap_data.size(), exp_n);
    if (exp_n == 4 && cap_data.size() == 4) begin
      d  = '0;
      fs = '0;
      for (int i = 0; i < 4; i++) begin
        d  = {d[23:0], cap_data[i]};
        fs = {fs[2:0], cap_fs[i]};
      end
      chk({name, "_data"}, d, exp_data);
      chk({name, "_fs"}, fs, 4'b1000);
    end
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_frame(tbl[i].frame);
      check_out($sformatf("tbl%0d", i), tbl[i].exp_n, tbl[i].exp_data);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
`ifdef FRAME_ALIGN_STATS_EN
      chk($sformatf("tbl%0d_err", i), sync_err_count, tbl[i].exp_err);
`endif
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{40'hBC11223344, 0, 32'h0,        1'b0, 8'd0};
    tbl[1]  = '{40'hBC11223344, 0, 32'h0,        1'b0, 8'd0};
    tbl[2]  = '{40'hBC11223344, 4, 32'h11223344, 1'b1, 8'd0};
    tbl[3]  = '{40'hBC11223344, 4, 32'h11223344, 1'b1, 8'd0};
    tbl[4]  = '{40'h00AABBCCDD, 4, 32'hAABBCCDD, 1'b1, 8'd1};
    tbl[5]  = '{40'hBC01020304, 4, 32'h01020304, 1'b1, 8'd1};
    tbl[6]  = '{40'h0012345678, 4, 32'h12345678, 1'b1, 8'd2};
    tbl[7]  = '{40'h0012345678, 4, 32'h12345678, 1'b1, 8'd3};
    tbl[8]  = '{40'h0012345678, 4, 32'h12345678, 1'b1, 8'd4};
    tbl[9]  = '{40'hBCA55A0FF0, 0, 32'h0,        1'b0, 8'd5};
    tbl[10] = '{40'hBCA55A0FF0, 0, 32'h0,        1'b0, 8'd5};
    tbl[11] = '{40'hBCA55A0FF0, 4, 32'hA55A0FF0, 1'b1, 8'd5};

    rst_n   = 1'b0;
    enable  = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_locked", locked, 1'b0);
`ifdef FRAME_ALIGN_STATS_EN
    chk("rst_err", sync_err_count, 8'd0);
`endif
    rst_n = 1'b1;

    // Lock, flywheel, then three misses.
    run_table(0, 8);

    // Fourth consecutive miss: lock drops right after that slot's LSB.
    clear_caps();
    for (int i = 7; i >= 1; i--) send_bit(1'b0);
    @(posedge clk); #1;
    chk("unlock_before_lsb", locked, 1'b1);
    send_bit(1'b0);
    @(posedge clk); #1;
    chk("unlock_after_lsb", locked, 1'b0);
    chk("unlock_no_valid", data_valid, 1'b0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    gap();
    check_out("unlocked_frame", 0, 32'h0);
`ifdef FRAME_ALIGN_STATS_EN
    chk("unlock_err", sync_err_count, 8'd5);
`endif

    // Relock needs three fresh syncs.
    run_table(9, 11);

    // Bit offset of 5, then frames BC A5 5A 0F F0.
    pulse_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_frame(40'hBCA55A0FF0);
    check_out("ofs_f1", 0, 32'h0);
    send_frame(40'hBCA55A0FF0);
    check_out("ofs_f2", 0, 32'h0);
    clear_caps();
    for (int i = 7; i >= 1; i--) send_bit(tbl[11].frame[32 + i]);
    @(posedge clk); #1;
    chk("lock_before_lsb", locked, 1'b0);
    send_bit(tbl[11].frame[32]);
    @(posedge clk); #1;
    chk("lock_after_lsb", locked, 1'b1);
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h0F); send_byte(8'hF0);
    gap();
    check_out("ofs_f3", 4, 32'hA55A0FF0);
    send_frame(40'hBCA55A0FF0);
    check_out("ofs_f4", 4, 32'hA55A0FF0);

    // Enable toggled 1-0-1-0: same bytes, pulses 8 enabled cycles apart.
    clear_caps();
    for (int k = 4; k >= 0; k--) begin
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk);
        data_in = tbl[11].frame[k*8 + i];
        enable  = 1'b1;
        @(negedge clk);
        data_in = ~tbl[11].frame[k*8 + i];
        enable  = 1'b0;
      end
    end
    #2;
    check_out("toggle", 4, 32'hA55A0FF0);
    if (cap_en.size() == 4) begin
      for (int i = 0; i < 3; i++) chk($sformatf("toggle_gap%0d", i), cap_en[i+1] - cap_en[i], 8);
    end

    // Reset while a payload pulse is on the outputs.
    send_byte(8'hBC); send_byte(8'hA5); send_byte(8'h5A);
    @(posedge clk); #1;
    chk("pre_rst_valid", data_valid, 1'b1);
    chk("pre_rst_data", data_out, 8'h5A);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_out", data_out, 8'h00);
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_fs", frame_start, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(40'hBC11223344);
    check_out("post_rst_f1", 0, 32'h0);
    chk("post_rst_f1_locked", locked, 1'b0);
    send_frame(40'hBC11223344);
    check_out("post_rst_f2", 0, 32'h0);
    chk("post_rst_f2_locked", locked, 1'b0);
    send_frame(40'hBC11223344);
    check_out("post_rst_f3", 4, 32'h11223344);
    chk("post_rst_f3_locked", locked, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
